sig_replay: RTL and testbench

SIG_REPLAY -- requirements
Module: sig_replay

---
 rtl/sig_replay_pkg.sv | 15 +
 rtl/sig_replay_if.sv | 25 ++
 rtl/sig_replay_dpram.sv | 26 ++
 rtl/sig_replay.sv | 139 +++++++++++++
 tb/tb_sig_replay.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sig_replay_pkg.sv
// sig_replay shared types: FSM state enum and default widths.
// Imported by the interface, the buffer and the top.
package sig_replay_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    FETCH,
    PRESENT
  } state_t;

endpackage

// File: rtl/sig_replay_if.sv
// Speaker-side valid/ready bundle of sig_replay.
// master: drives speaker/speaker_valid, samples speaker_ready.
interface sig_replay_if
  import sig_replay_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
) ();

  logic [DATA_WIDTH-1:0] speaker;
  logic                  speaker_valid;
  logic                  speaker_ready;

  modport master (
    output speaker,
    output speaker_valid,
    input  speaker_ready
  );

  modport slave (
    input  speaker,
    input  speaker_valid,
    output speaker_ready
  );

endinterface

// File: rtl/sig_replay_dpram.sv
// dpram: simple dual-port sample buffer, 1-cycle registered read.
// Ports: clk, ren, wen, raddr, waddr, win, rout. No reset on contents.
module dpram
  import sig_replay_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] win,
  output logic [DATA_WIDTH-1:0] rout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write-first: a read of the address being written returns new data.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= win;
    if (ren) rout <= (wen && waddr == raddr) ? win : mem[raddr];
  end

endmodule

// File: rtl/sig_replay.sv
// sig_replay: record `length` samples from microphone (en-qualified),
// then replay them on the speaker valid/ready port (spk, master).
// Ports: clk, rst (async, high), en, trigger, length, microphone,
// spk (speaker/speaker_valid/speaker_ready), busy, done.
// Optional macro SIG_REPLAY_LOOP_EN adds input `loop` (replay repeat).
module sig_replay
  import sig_replay_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] microphone,
`ifdef SIG_REPLAY_LOOP_EN
  input  logic                  loop,
`endif
  sig_replay_if.master          spk,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_n;
  logic [ADDR_WIDTH-1:0] len_q, len_n, last;
  logic [DATA_WIDTH-1:0] spk_q, spk_n, rout;
  logic                  valid_q, valid_n;
  logic                  done_q, done_n;
  logic                  wen;
  logic                  loop_on;

`ifdef SIG_REPLAY_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign last              = len_q - ONE;
  assign busy              = (state != IDLE);
  assign done              = done_q;
  assign spk.speaker       = spk_q;
  assign spk.speaker_valid = valid_q;

  // The read port is fed the next read address, so the word for
  // rd_addr is on rout throughout FETCH and lands in speaker as
  // PRESENT is entered.
  dpram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .ren   (1'b1),
    .wen   (wen),
    .raddr (rd_addr_n),
    .waddr (wr_addr),
    .win   (microphone),
    .rout  (rout)
  );

  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr;
    rd_addr_n = rd_addr;
    len_n     = len_q;
    spk_n     = spk_q;
    valid_n   = valid_q;
    done_n    = 1'b0;
    wen       = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger && length != '0) begin
          len_n     = length;
          wr_addr_n = '0;
          state_n   = RECORD;
        end
      end
      RECORD: begin
        if (en) begin
          wen       = 1'b1;
          wr_addr_n = wr_addr + ONE;
          if (wr_addr == last) begin
            rd_addr_n = '0;
            state_n   = FETCH;
          end
        end
      end
      FETCH: begin
        spk_n   = rout;
        valid_n = 1'b1;
        state_n = PRESENT;
      end
      PRESENT: begin
        if (spk.speaker_ready) begin
          valid_n = 1'b0;
          if (rd_addr == last) begin
            done_n = 1'b1;
            if (loop_on) begin
              rd_addr_n = '0;
              state_n   = FETCH;
            end else begin
              state_n = IDLE;
            end
          end else begin
            rd_addr_n = rd_addr + ONE;
            state_n   = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
      len_q   <= '0;
      spk_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      wr_addr <= wr_addr_n;
      rd_addr <= rd_addr_n;
      len_q   <= len_n;
      spk_q   <= spk_n;
      valid_q <= valid_n;
      done_q  <= done_n;
    end
  end

endmodule

// File: tb/tb_sig_replay.sv
// Directed self-checking bench for sig_replay.
// Define SIG_REPLAY_LOOP_EN to also exercise the loop port.
module tb_sig_replay;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       trigger;
  logic [8:0] length;
  logic [7:0] microphone;
  logic       busy;
  logic       done;
`ifdef SIG_REPLAY_LOOP_EN
  logic       loop;
`endif

  int errors = 0;
  int checks = 0;

  sig_replay_if #(.DATA_WIDTH(8)) dv ();

  sig_replay #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .trigger    (trigger),
    .length     (length),
    .microphone (microphone),
`ifdef SIG_REPLAY_LOOP_EN
    .loop       (loop),
`endif
    .spk        (dv),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [8:0] l);
    trigger = 1'b1;
    length  = l;
    tick();
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    trigger = 1'b0;
    length = '0;
    microphone = '0;
    dv.speaker_ready = 1'b0;
`ifdef SIG_REPLAY_LOOP_EN
    loop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (dv.speaker !== 8'h00 || dv.speaker_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset spk=%h v=%b busy=%b done=%b want 00/0/0/0",
               dv.speaker, dv.speaker_valid, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int k;
    dv.speaker_ready = 1'b1;
    start(4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      microphone = d[i];
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end
      while (!dv.speaker_valid && k < 8);
      checks++;
      if (dv.speaker_valid !== 1'b1 || dv.speaker !== d[i] ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL basic_s%0d got %h v=%b done=%b want %h v=1",
                 i, dv.speaker, dv.speaker_valid, done, d[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dv.speaker_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b v=%b want 1/0/0",
               done, busy, dv.speaker_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || dv.speaker !== 8'h44) begin
      errors++;
      $display("FAIL basic_after done=%b spk=%h want 0/44",
               done, dv.speaker);
    end
  endtask

  task automatic test_en_toggle();
    logic [4:0] pat = 5'b10101;
    logic [7:0] e [3] = '{8'd1, 8'd3, 8'd5};
    int k;
    dv.speaker_ready = 1'b1;
    start(3);
    for (int c = 0; c < 5; c++) begin
      en = pat[4-c];
      microphone = 8'(c + 1);
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end
      while (!dv.speaker_valid && k < 8);
      checks++;
      if (dv.speaker_valid !== 1'b1 || dv.speaker !== e[i]) begin
        errors++;
        $display("FAIL entog_s%0d got %h v=%b want %h",
                 i, dv.speaker, dv.speaker_valid, e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL entog_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d [3] = '{8'hA0, 8'hA1, 8'hA2};
    int k;
    dv.speaker_ready = 1'b1;
    start(3);
    for (int i = 0; i < 3; i++) begin
      en = 1'b1;
      microphone = d[i];
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end
      while (!dv.speaker_valid && k < 8);
      checks++;
      if (dv.speaker_valid !== 1'b1 || dv.speaker !== d[i]) begin
        errors++;
        $display("FAIL stall_s%0d got %h v=%b want %h",
                 i, dv.speaker, dv.speaker_valid, d[i]);
      end
      if (i == 0) begin
        @(posedge clk);
        #1 dv.speaker_ready = 1'b0;
      end
      if (i == 1) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++;
          if (dv.speaker_valid !== 1'b1 || dv.speaker !== 8'hA1) begin
            errors++;
            $display("FAIL stall_hold%0d got %h v=%b want A1 v=1",
                     s, dv.speaker, dv.speaker_valid);
          end
        end
        dv.speaker_ready = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d [2] = '{8'h5A, 8'h5B};
    int k;
    dv.speaker_ready = 1'b1;
    start(4);
    en = 1'b1;
    microphone = 8'h99;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dv.speaker_valid !== 1'b0 ||
        dv.speaker !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstrec busy=%b v=%b spk=%h done=%b want 0/0/00/0",
               busy, dv.speaker_valid, dv.speaker, done);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dv.speaker_ready = 1'b0;
    start(2);
    en = 1'b1;
    microphone = 8'h31;
    tick();
    microphone = 8'h32;
    tick();
    en = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!dv.speaker_valid && k < 8);
    checks++;
    if (dv.speaker_valid !== 1'b1 || dv.speaker !== 8'h31) begin
      errors++;
      $display("FAIL rstpre_s0 got %h v=%b want 31", dv.speaker,
               dv.speaker_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dv.speaker_valid !== 1'b0 ||
        dv.speaker !== 8'h00) begin
      errors++;
      $display("FAIL rstpre busy=%b v=%b spk=%h want 0/0/00",
               busy, dv.speaker_valid, dv.speaker);
    end
    trigger = 1'b1;
    length = 9'd2;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio busy=%b want 0", busy);
    end
    trigger = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dv.speaker_ready = 1'b1;
    start(2);
    for (int i = 0; i < 2; i++) begin
      en = 1'b1;
      microphone = d[i];
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end
      while (!dv.speaker_valid && k < 8);
      checks++;
      if (dv.speaker_valid !== 1'b1 || dv.speaker !== d[i]) begin
        errors++;
        $display("FAIL rstnext_s%0d got %h v=%b want %h",
                 i, dv.speaker, dv.speaker_valid, d[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstnext_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_ignored();
    int k;
    trigger = 1'b1;
    length = 9'd0;
    tick();
    trigger = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dv.speaker_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL len0 busy=%b v=%b done=%b want 0/0/0",
               busy, dv.speaker_valid, done);
    end
    dv.speaker_ready = 1'b0;
    start(2);
    length = 9'd5;
    en = 1'b1;
    microphone = 8'h61;
    tick();
    microphone = 8'h62;
    tick();
    en = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!dv.speaker_valid && k < 8);
    checks++;
    if (dv.speaker_valid !== 1'b1 || dv.speaker !== 8'h61) begin
      errors++;
      $display("FAIL ign_s0 got %h v=%b want 61", dv.speaker,
               dv.speaker_valid);
    end
    trigger = 1'b1;
    length = 9'd3;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if (dv.speaker_valid !== 1'b1 || dv.speaker !== 8'h61 ||
          busy !== 1'b1) begin
        errors++;
        $display("FAIL ign_trig%0d spk=%h v=%b busy=%b want 61/1/1",
                 s, dv.speaker, dv.speaker_valid, busy);
      end
    end
    trigger = 1'b0;
    dv.speaker_ready = 1'b1;
    @(posedge clk);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!dv.speaker_valid && k < 8);
    checks++;
    if (dv.speaker_valid !== 1'b1 || dv.speaker !== 8'h62) begin
      errors++;
      $display("FAIL ign_s1 got %h v=%b want 62", dv.speaker,
               dv.speaker_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_len1();
    int k;
    dv.speaker_ready = 1'b1;
    start(1);
    en = 1'b1;
    microphone = 8'h77;
    tick();
    en = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!dv.speaker_valid && k < 8);
    checks++;
    if (dv.speaker_valid !== 1'b1 || dv.speaker !== 8'h77) begin
      errors++;
      $display("FAIL len1 got %h v=%b want 77", dv.speaker,
               dv.speaker_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len1_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_full();
    logic [7:0] e;
    int k;
    dv.speaker_ready = 1'b1;
    start(9'd511);
    for (int i = 0; i < 511; i++) begin
      en = 1'b1;
      microphone = 8'(i) ^ 8'hC3;
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 511; i++) begin
      e = 8'(i) ^ 8'hC3;
      k = 0;
      do begin @(negedge clk); k++; end
      while (!dv.speaker_valid && k < 8);
      checks++;
      if (dv.speaker_valid !== 1'b1 || dv.speaker !== e) begin
        errors++;
        $display("FAIL full_s%0d got %h v=%b want %h",
                 i, dv.speaker, dv.speaker_valid, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

`ifdef SIG_REPLAY_LOOP_EN
  task automatic test_loop();
    logic [7:0] d [2] = '{8'hA5, 8'h5A};
    int k;
    dv.speaker_ready = 1'b1;
    loop = 1'b1;
    start(2);
    for (int i = 0; i < 2; i++) begin
      en = 1'b1;
      microphone = d[i];
      tick();
    end
    en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        k = 0;
        do begin @(negedge clk); k++; end
        while (!dv.speaker_valid && k < 8);
        checks++;
        if (dv.speaker_valid !== 1'b1 || dv.speaker !== d[i]) begin
          errors++;
          $display("FAIL loop_r%0d_s%0d got %h v=%b want %h",
                   r, i, dv.speaker, dv.speaker_valid, d[i]);
        end
      end
      if (r == 2) loop = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== (r < 2)) begin
        errors++;
        $display("FAIL loop_done%0d done=%b busy=%b want 1/%0d",
                 r, done, busy, (r < 2));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_en_toggle();
    test_stall();
    test_reset_mid();
    test_ignored();
    test_len1();
    test_full();
`ifdef SIG_REPLAY_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
